// File: rtl/sccpu_dbg_pkg.sv
// -----------------------------------------------------------------------------
// sccpu_dbg_pkg
// Shared debug definitions for the single-cycle CPU run controller:
//   - run_state_t : controller state (HALTED / RUNNING / STEPPING)
//   - CMD_*       : host command opcodes carried on cmd_op
//   - STOP_*      : stop_cause encodings reported while halted
// -----------------------------------------------------------------------------
package sccpu_dbg_pkg;

   typedef enum logic [1:0] {
      ST_HALTED   = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_STEPPING = 2'd2
   } run_state_t;

   localparam logic [1:0] CMD_HALT = 2'd0;
   localparam logic [1:0] CMD_RUN  = 2'd1;
   localparam logic [1:0] CMD_STEP = 2'd2;
   localparam logic [1:0] CMD_CLR  = 2'd3;

   localparam logic [1:0] STOP_RST  = 2'd0;
   localparam logic [1:0] STOP_HOST = 2'd1;
   localparam logic [1:0] STOP_STEP = 2'd2;
   localparam logic [1:0] STOP_BP   = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset (count -> 0)
//   i_inc in  increment request; ignored once the count is all-ones
//   i_clr in  clear request; wins over i_inc in the same cycle
//   o_cnt out current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/sccpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// sccpu_run_ctrl
// Run/halt/single-step controller for the single-cycle CPU. Gates the CPU
// clock-enable according to host commands and keeps a retired-instruction
// counter.
// Optional feature macro: RUNCTRL_BP_EN (PC breakpoint support).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   host command handshake (ready is always 1)
//   cmd_op, cmd_arg   command opcode (HALT/RUN/STEP/CLR) and step count
//   pc                current CPU PC
//   bp_addr, bp_en    breakpoint address / arm (only with RUNCTRL_BP_EN)
//   cpu_en            CPU clock-enable
//   halted            controller is in HALTED
//   stop_cause        why the controller last stopped
//   cmd_err           one-cycle pulse after a rejected command
//   retired           saturating count of enabled cycles
// Handshake: a command transfers on every rising edge where cmd_valid=1;
// cmd_ready is tied high so the host never has to wait.
// -----------------------------------------------------------------------------
module sccpu_run_ctrl
   import sccpu_dbg_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_arg,
   input  logic [31:0]       pc,
   input  logic [31:0]       bp_addr,
   input  logic              bp_en,
   output logic              cpu_en,
   output logic              halted,
   output logic [1:0]        stop_cause,
   output logic              cmd_err,
   output logic [CNT_W-1:0]  retired
);

   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

   run_state_t        r_state,      w_state_nxt;
   logic [STEP_W-1:0] r_step_cnt,   w_step_cnt_nxt;
   logic [1:0]        r_stop_cause, w_stop_cause_nxt;
   logic              r_cmd_err,    w_cmd_err_nxt;
   logic              w_bp_hit;
   logic              w_cpu_en;
   logic              w_clr;

`ifdef RUNCTRL_BP_EN
   // skip_bp lets the instruction sitting on the breakpoint execute once
   // after a resume instead of re-triggering immediately.
   logic r_skip_bp, w_skip_bp_nxt;

   assign w_bp_hit = bp_en && (pc == bp_addr) && !r_skip_bp &&
                     (r_state != ST_HALTED);
`else
   logic w_unused_bp;

   assign w_unused_bp = ^{pc, bp_addr, bp_en};
   assign w_bp_hit    = 1'b0;
`endif

   assign w_cpu_en = (r_state != ST_HALTED) && !w_bp_hit;
   assign w_clr    = cmd_valid && (cmd_op == CMD_CLR);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_HALTED;
         r_step_cnt   <= '0;
         r_stop_cause <= STOP_RST;
         r_cmd_err    <= 1'b0;
`ifdef RUNCTRL_BP_EN
         r_skip_bp    <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_step_cnt   <= w_step_cnt_nxt;
         r_stop_cause <= w_stop_cause_nxt;
         r_cmd_err    <= w_cmd_err_nxt;
`ifdef RUNCTRL_BP_EN
         r_skip_bp    <= w_skip_bp_nxt;
`endif
      end
   end

   // Autonomous events (step completion, breakpoint) are evaluated first;
   // an accepted command then overrides them. Rejected commands leave the
   // autonomous result untouched so step counting stays exact.
   always_comb begin
      w_state_nxt      = r_state;
      w_step_cnt_nxt   = r_step_cnt;
      w_stop_cause_nxt = r_stop_cause;
      w_cmd_err_nxt    = 1'b0;
`ifdef RUNCTRL_BP_EN
      w_skip_bp_nxt    = r_skip_bp && !w_cpu_en;
`endif

      if ((r_state == ST_STEPPING) && w_cpu_en) begin
         w_step_cnt_nxt = r_step_cnt - 1'b1;
         if (r_step_cnt == STEP_ONE) begin
            w_state_nxt      = ST_HALTED;
            w_stop_cause_nxt = STOP_STEP;
         end
      end

      if (w_bp_hit) begin
         w_state_nxt      = ST_HALTED;
         w_stop_cause_nxt = STOP_BP;
      end

      if (cmd_valid) begin
         case (cmd_op)
            CMD_HALT: begin
               w_state_nxt      = ST_HALTED;
               w_stop_cause_nxt = STOP_HOST;
            end
            CMD_RUN: begin
               if (r_state == ST_HALTED) begin
                  w_state_nxt = ST_RUNNING;
`ifdef RUNCTRL_BP_EN
                  w_skip_bp_nxt = 1'b1;
`endif
               end else begin
                  w_cmd_err_nxt = 1'b1;
               end
            end
            CMD_STEP: begin
               if (r_state == ST_HALTED) begin
                  w_state_nxt    = ST_STEPPING;
                  w_step_cnt_nxt = (cmd_arg == '0) ? STEP_ONE : cmd_arg;
`ifdef RUNCTRL_BP_EN
                  w_skip_bp_nxt  = 1'b1;
`endif
               end else begin
                  w_cmd_err_nxt = 1'b1;
               end
            end
            default: begin
               // CMD_CLR only touches the retired counter.
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_retired (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_cpu_en),
      .i_clr (w_clr),
      .o_cnt (retired)
   );

   assign cmd_ready  = 1'b1;
   assign cpu_en     = w_cpu_en;
   assign halted     = (r_state == ST_HALTED);
   assign stop_cause = r_stop_cause;
   assign cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_sccpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sccpu_run_ctrl
// Directed bench for sccpu_run_ctrl. A second instance with a 4-bit counter
// exercises saturation. Breakpoint scenario is built when RUNCTRL_BP_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_sccpu_run_ctrl;

   localparam logic [1:0] OP_HALT = 2'd0;
   localparam logic [1:0] OP_RUN  = 2'd1;
   localparam logic [1:0] OP_STEP = 2'd2;
   localparam logic [1:0] OP_CLR  = 2'd3;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic [31:0] pc;
   logic [31:0] bp_addr;
   logic        bp_en;
   logic        cpu_en;
   logic        halted;
   logic [1:0]  stop_cause;
   logic        cmd_err;
   logic [31:0] retired;

   logic        s_cmd_valid;
   logic        s_cmd_ready;
   logic [1:0]  s_cmd_op;
   logic [15:0] s_cmd_arg;
   logic        s_cpu_en;
   logic        s_halted;
   logic [1:0]  s_stop_cause;
   logic        s_cmd_err;
   logic [3:0]  s_retired;

   int total;
   int bad;

   sccpu_run_ctrl #(.CNT_W(32), .STEP_W(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_arg    (cmd_arg),
      .pc         (pc),
      .bp_addr    (bp_addr),
      .bp_en      (bp_en),
      .cpu_en     (cpu_en),
      .halted     (halted),
      .stop_cause (stop_cause),
      .cmd_err    (cmd_err),
      .retired    (retired)
   );

   sccpu_run_ctrl #(.CNT_W(4), .STEP_W(16)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (s_cmd_valid),
      .cmd_ready  (s_cmd_ready),
      .cmd_op     (s_cmd_op),
      .cmd_arg    (s_cmd_arg),
      .pc         (32'h0),
      .bp_addr    (32'h0),
      .bp_en      (1'b0),
      .cpu_en     (s_cpu_en),
      .halted     (s_halted),
      .stop_cause (s_stop_cause),
      .cmd_err    (s_cmd_err),
      .retired    (s_retired)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // minimal CPU model: PC advances by 4 on each enabled cycle
   always @(posedge clk) begin
      if (rst) pc <= 32'h0;
      else if (cpu_en) pc <= pc + 32'd4;
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [1:0] op, input logic [15:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_HALT;
      cmd_arg   = 16'h0;
   endtask

   task automatic sat_send(input logic [1:0] op);
      s_cmd_valid = 1'b1;
      s_cmd_op    = op;
      @(posedge clk);
      #1;
      s_cmd_valid = 1'b0;
      s_cmd_op    = OP_HALT;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted got=%0b exp=1", halted); end
      total++; if (stop_cause !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d exp=0", stop_cause); end
      total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en got=%0b exp=0", cpu_en); end
      total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL reset_cmd_err got=%0b exp=0", cmd_err); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
   endtask

   task automatic test_run_halt();
      send(OP_RUN, 16'h0);
      // first cycle after acceptance is enabled
      total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL run_first_en got=%0b exp=1", cpu_en); end
      repeat (9) begin @(posedge clk); #1; end
      // 9 cycles retired, 10th enabled now; HALT lands on it so it executes
      total++; if (retired !== 32'd9) begin bad++; $display("FAIL run_retired9 got=%0d exp=9", retired); end
      send(OP_HALT, 16'h0);
      total++; if (retired !== 32'd10) begin bad++; $display("FAIL halt_retired got=%0d exp=10", retired); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_halted got=%0b exp=1", halted); end
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL halt_cpu_en got=%0b exp=0", cpu_en); end
      total++; if (stop_cause !== 2'd1) begin bad++; $display("FAIL halt_cause got=%0d exp=1", stop_cause); end
   endtask

   task automatic test_step();
      int n;
      send(OP_CLR, 16'h0);
      total++; if (retired !== 32'd0) begin bad++; $display("FAIL clr_halted got=%0d exp=0", retired); end
      send(OP_STEP, 16'd3);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (cpu_en) n++;
         @(posedge clk); #1;
      end
      total++; if (n !== 3) begin bad++; $display("FAIL step3_cycles got=%0d exp=3", n); end
      total++; if (retired !== 32'd3) begin bad++; $display("FAIL step3_retired got=%0d exp=3", retired); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL step3_halted got=%0b exp=1", halted); end
      total++; if (stop_cause !== 2'd2) begin bad++; $display("FAIL step3_cause got=%0d exp=2", stop_cause); end
      send(OP_STEP, 16'd0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (cpu_en) n++;
         @(posedge clk); #1;
      end
      total++; if (n !== 1) begin bad++; $display("FAIL step0_cycles got=%0d exp=1", n); end
      total++; if (retired !== 32'd4) begin bad++; $display("FAIL step0_retired got=%0d exp=4", retired); end
      total++; if (stop_cause !== 2'd2) begin bad++; $display("FAIL step0_cause got=%0d exp=2", stop_cause); end
   endtask

   task automatic test_err_clr();
      send(OP_RUN, 16'h0);
      total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_idle got=%0b exp=0", cmd_err); end
      send(OP_RUN, 16'h0);
      total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_run_pulse got=%0b exp=1", cmd_err); end
      total++; if (cpu_en !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL err_run_state got=en%0b/h%0b exp=en1/h0", cpu_en, halted); end
      @(posedge clk); #1;
      total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_pulse_end got=%0b exp=0", cmd_err); end
      send(OP_STEP, 16'd5);
      total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_step_pulse got=%0b exp=1", cmd_err); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL err_step_state got=%0b exp=0", halted); end
      send(OP_CLR, 16'h0);
      total++; if (retired !== 32'd0) begin bad++; $display("FAIL clr_run got=%0d exp=0", retired); end
      @(posedge clk); #1;
      total++; if (retired !== 32'd1) begin bad++; $display("FAIL clr_resume got=%0d exp=1", retired); end
      send(OP_HALT, 16'h0);
   endtask

`ifdef RUNCTRL_BP_EN
   task automatic test_bp();
      int n;
      do_reset();
      bp_addr = 32'h0000_000C;
      bp_en   = 1'b1;
      send(OP_RUN, 16'h0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (cpu_en) n++;
         @(posedge clk); #1;
      end
      total++; if (n !== 3) begin bad++; $display("FAIL bp_cycles got=%0d exp=3", n); end
      total++; if (pc !== 32'hC) begin bad++; $display("FAIL bp_pc got=%0h exp=c", pc); end
      total++; if (stop_cause !== 2'd3) begin bad++; $display("FAIL bp_cause got=%0d exp=3", stop_cause); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL bp_halted got=%0b exp=1", halted); end
      send(OP_RUN, 16'h0);
      total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL bp_resume_en got=%0b exp=1", cpu_en); end
      @(posedge clk); #1;
      total++; if (pc !== 32'h10 || halted !== 1'b0) begin bad++; $display("FAIL bp_resume_pc got=%0h/h%0b exp=10/h0", pc, halted); end
      send(OP_HALT, 16'h0);
      bp_en = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_step();
      send(OP_STEP, 16'd8);
      repeat (3) begin @(posedge clk); #1; end
      total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL midstep_en got=%0b exp=1", cpu_en); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL midrst_halted got=%0b exp=1", halted); end
      total++; if (retired !== 32'd0) begin bad++; $display("FAIL midrst_retired got=%0d exp=0", retired); end
      total++; if (stop_cause !== 2'd0) begin bad++; $display("FAIL midrst_cause got=%0d exp=0", stop_cause); end
      total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL midrst_cpu_en got=%0b exp=0", cpu_en); end
   endtask

   task automatic test_saturation();
      sat_send(OP_RUN);
      repeat (20) begin @(posedge clk); #1; end
      total++; if (s_retired !== 4'hF) begin bad++; $display("FAIL sat_value got=%0d exp=15", s_retired); end
      total++; if (s_cpu_en !== 1'b1) begin bad++; $display("FAIL sat_running got=%0b exp=1", s_cpu_en); end
      repeat (3) begin @(posedge clk); #1; end
      total++; if (s_retired !== 4'hF) begin bad++; $display("FAIL sat_hold got=%0d exp=15", s_retired); end
      sat_send(OP_HALT);
      total++; if (s_halted !== 1'b1 || s_stop_cause !== 2'd1) begin bad++; $display("FAIL sat_halt got=h%0b/c%0d exp=h1/c1", s_halted, s_stop_cause); end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = OP_HALT;
      cmd_arg     = 16'h0;
      bp_addr     = 32'h0;
      bp_en       = 1'b0;
      s_cmd_valid = 1'b0;
      s_cmd_op    = OP_HALT;
      s_cmd_arg   = 16'h0;

      test_reset();
      test_run_halt();
      test_step();
      test_err_clr();
`ifdef RUNCTRL_BP_EN
      test_bp();
`endif
      test_reset_mid_step();
      test_saturation();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sccpu_run_ctrl.md
# sccpu_run_ctrl

Run/halt/single-step controller for the single-cycle CPU (`sccomp`). It sits between a host command port (bench, UART loader or board switches) and the CPU's clock-enable, gating instruction execution. It supports free run, N-instruction stepping, host halt and an optional PC breakpoint, and keeps a retired-instruction counter for debug readout.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.
- `STEP_W`, 16: width of the step-count argument.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  controller accepts the command this cycle.
- `cmd_op`  in  2  command: 0 HALT, 1 RUN, 2 STEP, 3 CLR (clear counter).
- `cmd_arg`  in  STEP_W  step count for STEP.
- `pc`  in  32  current CPU PC (combinational from the CPU).
- `bp_addr`  in  32  breakpoint address (used only with `RUNCTRL_BP_EN`).
- `bp_en`  in  1  breakpoint armed (used only with `RUNCTRL_BP_EN`).
- `cpu_en`  out  1  CPU clock-enable; the PC/regfile/memory write only when high.
- `halted`  out  1  state is HALTED.
- `stop_cause`  out  2  0 reset, 1 host halt, 2 step done, 3 breakpoint.
- `cmd_err`  out  1  one-cycle pulse: command rejected.
- `retired`  out  CNT_W  instructions executed (cycles with `cpu_en`=1).

## Operation
- States: HALTED, RUNNING, STEPPING. Reset → HALTED, `stop_cause`=0, `retired`=0, step counter 0, `cmd_err`=0, `skip_bp`=0.
- `cmd_ready` is constant 1; a command is accepted on any cycle with `cmd_valid`=1.
- HALT: any state → HALTED, `stop_cause`=1. In HALTED it still rewrites `stop_cause`=1.
- RUN: HALTED → RUNNING. In RUNNING/STEPPING: ignored, `cmd_err` pulses.
- STEP: HALTED → STEPPING, step counter = `cmd_arg`, or 1 if `cmd_arg`=0. In RUNNING/STEPPING: ignored, `cmd_err` pulses.
- CLR: `retired` ← 0 in any state. No state change.
- `cpu_en` = (state ≠ HALTED) && !bp_hit. It is combinational and is not asserted in the cycle a command is accepted.
- STEPPING: each cycle with `cpu_en`=1 decrements the counter. When the counter is 1 and `cpu_en`=1, go to HALTED next edge with `stop_cause`=2. Exactly N instructions execute.
- `retired` increments on every cycle with `cpu_en`=1 and saturates at all-ones.
- Simultaneous events: a command accepted in the same cycle as step completion or a breakpoint takes priority. CLR combined with an increment yields 0.

## Timing
- Command → first enabled cycle: 1 clock (edge accepts, next cycle `cpu_en`=1).
- HALT accepted in cycle t: the instruction in cycle t still executes if `cpu_en`=1 in t. `cpu_en`=0 from t+1.
- STEP N: `cpu_en` high for exactly N consecutive cycles (absent HALT or breakpoint), then `halted`=1.
- Reset mid-run: on the reset edge all state returns to reset values. `cpu_en`=0 from the next cycle.

## Configuration
- `RUNCTRL_BP_EN` defined:
  - bp_hit = `bp_en` && (`pc`==`bp_addr`) && !skip_bp && state≠HALTED.
  - On bp_hit, the instruction at `bp_addr` does not execute; next state is HALTED with `stop_cause`=3.
  - skip_bp is set when RUN/STEP is accepted and cleared after the first `cpu_en`=1 cycle, so resuming from a breakpoint executes that instruction.
- Macro undefined: bp_hit is constant 0, `bp_addr`/`bp_en` are unused, and no skip_bp flop is built.

## Structure
- Shared package `sccpu_dbg_pkg` holds:
  - state enum (HALTED/RUNNING/STEPPING);
  - `cmd_op` encodings (CMD_HALT, CMD_RUN, CMD_STEP, CMD_CLR);
  - `stop_cause` encodings (STOP_RST, STOP_HOST, STOP_STEP, STOP_BP).
- One sub-module: `sat_counter` (parameterized width, inc/clr, saturating) for `retired`. Everything else stays in a single always block plus combinational `cpu_en`.

## Test plan
- Reset, then RUN: `cpu_en`=1 from the cycle after acceptance. HALT after 10 enabled cycles → `retired`=10 (or 11 if HALT lands on an enabled cycle, per timing rule), `stop_cause`=1.
- STEP with `cmd_arg`=3 from HALTED → `cpu_en` high exactly 3 cycles, `retired`=3, `stop_cause`=2. STEP with `cmd_arg`=0 → exactly 1 cycle.
- RUN issued while RUNNING → `cmd_err` 1-cycle pulse, state unchanged. CLR while running → `retired`=0 on next edge, then counting resumes.
- `RUNCTRL_BP_EN`, `bp_addr`=0x0000_000C, `pc` advancing by 4 from 0 → 3 enabled cycles, `cpu_en`=0 at pc=0xC, `stop_cause`=3. RUN again → pc 0xC executes, no immediate re-hit.
- Reset asserted during STEPPING (counter=5) → next cycle HALTED, `retired`=0, `stop_cause`=0, `cpu_en`=0.
- Saturation: with `CNT_W`=4, RUN for 20 cycles → `retired`=15 and holds.
